// File: rtl/i2c_slave_fifo_pkg.sv
// Shared definitions for the I2C slave receive path: transaction states and
// the address-byte decode used by the byte handler.
package i2c_slave_fifo_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_DATA   = 2'd2,
    S_IGNORE = 2'd3
  } state_t;

  // FIFO entry is {first-byte flag, data byte}.
  localparam int FIFO_WIDTH = 9;

  // Only a write to our own address is accepted; a read is refused.
  function automatic logic addr_write_match(input logic [7:0] addr_byte,
                                            input logic [6:0] own_addr);
    return (addr_byte[7:1] == own_addr) && (addr_byte[0] == 1'b0);
  endfunction

endpackage

// File: rtl/i2c_slave_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is visible with zero latency and
// the last popped entry stays on the output while empty.
module sync_fifo #(
  parameter int WIDTH      = 9,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  valid,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic [WIDTH-1:0]      last_reg;
  logic                  push_ok;
  logic                  pop_ok;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign full      = (count_reg == DEPTH_CNT);
  assign valid     = (count_reg != '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && valid;
  assign count     = count_reg;
  assign head_data = valid ? mem[rd_ptr_reg] : last_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      last_reg   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        last_reg   <= mem[rd_ptr_reg];
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/i2c_slave_fifo.sv
// I2C slave byte handler: decodes the address byte, ACKs and queues data
// bytes of write transactions to our address into a show-ahead FIFO.
module i2c_slave_fifo
  import i2c_slave_fifo_pkg::*;
#(
  parameter logic [6:0] I2C_ADDRESS = 7'd0,
  parameter int         DEPTH_LOG2  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [7:0]          write_data,
  input  logic                wr,
  output logic                wr_ack,
  output logic [7:0]          rx_data,
  output logic                rx_first,
  output logic                rx_valid,
  input  logic                rx_rd,
  output logic [DEPTH_LOG2:0] rx_count,
  output logic                overflow
);

  state_t state_reg, state_next;
  logic   wr_ack_reg, wr_ack_next;
  logic   first_reg, first_next;
  logic   overflow_reg, overflow_next;
  logic   push;
  logic   fifo_full;
  logic [FIFO_WIDTH-1:0] head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      wr_ack_reg   <= 1'b0;
      first_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ack_reg   <= wr_ack_next;
      first_reg    <= first_next;
      overflow_reg <= overflow_next;
    end
  end

  // Bus conditions take precedence; a byte strobed alongside them is dropped.
  always_comb begin
    state_next    = state_reg;
    wr_ack_next   = wr_ack_reg;
    first_next    = first_reg;
    overflow_next = 1'b0;
    push          = 1'b0;
    if (start) begin
      state_next = S_ADDR;
    end else if (stop) begin
      state_next = S_IDLE;
    end else if (wr) begin
      case (state_reg)
        S_ADDR: begin
          if (addr_write_match(write_data, I2C_ADDRESS)) begin
            wr_ack_next = 1'b1;
            first_next  = 1'b1;
            state_next  = S_DATA;
          end else begin
            wr_ack_next = 1'b0;
            state_next  = S_IGNORE;
          end
        end
        S_DATA: begin
          if (!fifo_full) begin
            push        = 1'b1;
            wr_ack_next = 1'b1;
            first_next  = 1'b0;
          end else begin
            wr_ack_next   = 1'b0;
            overflow_next = 1'b1;
            state_next    = S_IGNORE;
          end
        end
        default: wr_ack_next = 1'b0;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH      (FIFO_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({first_reg, write_data}),
    .pop       (rx_rd),
    .head_data (head),
    .valid     (rx_valid),
    .full      (fifo_full),
    .count     (rx_count)
  );

  assign rx_first = head[8];
  assign rx_data  = head[7:0];
  assign wr_ack   = wr_ack_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_i2c_slave_fifo.sv
// Self-checking bench for i2c_slave_fifo (address 0x21, depth 4): vector table,
// hand-written corner sequences, then random traffic against a queue model.
module tb_i2c_slave_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic       wr = 1'b0;
  logic       rx_rd = 1'b0;
  logic       wr_ack;
  logic [7:0] rx_data;
  logic       rx_first;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       overflow;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  i2c_slave_fifo #(.I2C_ADDRESS(7'h21), .DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .write_data(write_data), .wr(wr), .wr_ack(wr_ack),
    .rx_data(rx_data), .rx_first(rx_first), .rx_valid(rx_valid),
    .rx_rd(rx_rd), .rx_count(rx_count), .overflow(overflow)
  );

  typedef struct {
    logic       st, sp, w;
    logic [7:0] d;
    logic       rd;
    logic       e_ack;
    logic [2:0] e_cnt;
    logic       e_valid;
    logic [8:0] e_head;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic sp, logic w, logic [7:0] d, logic rd,
                              logic e_ack, logic [2:0] e_cnt, logic e_valid,
                              logic [8:0] e_head, logic e_ovf);
    vec_t v;
    v.st = st; v.sp = sp; v.w = w; v.d = d; v.rd = rd;
    v.e_ack = e_ack; v.e_cnt = e_cnt; v.e_valid = e_valid;
    v.e_head = e_head; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic e_ack, input logic [2:0] e_cnt,
                           input logic e_valid, input logic [8:0] e_head, input logic e_ovf);
    chk({tag, ".wr_ack"}, 32'(wr_ack), 32'(e_ack));
    chk({tag, ".rx_count"}, 32'(rx_count), 32'(e_cnt));
    chk({tag, ".rx_valid"}, 32'(rx_valid), 32'(e_valid));
    chk({tag, ".head"}, 32'({rx_first, rx_data}), 32'(e_head));
    chk({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
  endtask

  // One bus cycle: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cycle(input logic st, input logic sp, input logic w,
                       input logic [7:0] d, input logic rd);
    @(negedge clk);
    start = st; stop = sp; wr = w; write_data = d; rx_rd = rd;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; wr = 1'b0; rx_rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [8:0] model_q[$];
  logic [8:0] last_head;
  int         mode;       // 0 idle, 1 expect address, 2 accepting data, 3 ignoring
  logic       m_ack, m_first, m_ovf;

  initial begin
    // Basic write, pops incl. pop-on-empty, wrong address, read address.
    tbl.push_back(mk(1,0,0,8'h00,0, 0,0,0,9'h000,0));
    tbl.push_back(mk(0,0,1,8'h42,0, 1,0,0,9'h000,0));
    tbl.push_back(mk(0,0,1,8'hA5,0, 1,1,1,9'h1A5,0));
    tbl.push_back(mk(0,0,1,8'h3C,0, 1,2,1,9'h1A5,0));
    tbl.push_back(mk(0,1,0,8'h00,0, 1,2,1,9'h1A5,0));
    tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1,9'h03C,0));
    tbl.push_back(mk(0,0,0,8'h00,1, 1,0,0,9'h03C,0));
    tbl.push_back(mk(0,0,0,8'h00,1, 1,0,0,9'h03C,0));
    tbl.push_back(mk(1,0,0,8'h00,0, 1,0,0,9'h03C,0));
    tbl.push_back(mk(0,0,1,8'h44,0, 0,0,0,9'h03C,0));
    tbl.push_back(mk(0,0,1,8'h11,0, 0,0,0,9'h03C,0));
    tbl.push_back(mk(1,0,0,8'h00,0, 0,0,0,9'h03C,0));
    tbl.push_back(mk(0,0,1,8'h43,0, 0,0,0,9'h03C,0));
    tbl.push_back(mk(0,0,1,8'h55,0, 0,0,0,9'h03C,0));
    tbl.push_back(mk(0,1,0,8'h00,0, 0,0,0,9'h03C,0));

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("reset", 0, 0, 0, 9'h000, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].st, tbl[i].sp, tbl[i].w, tbl[i].d, tbl[i].rd);
      check_all($sformatf("vec%0d", i), tbl[i].e_ack, tbl[i].e_cnt, tbl[i].e_valid,
                tbl[i].e_head, tbl[i].e_ovf);
    end

    // Overflow: four bytes fit, the fifth is refused with one overflow pulse.
    cycle(1,0,0,8'h00,0);
    cycle(0,0,1,8'h42,0);
    for (int i = 1; i <= 4; i++) begin
      cycle(0,0,1,8'(i),0);
      chk($sformatf("ovf.ack%0d", i), 32'(wr_ack), 32'd1);
    end
    cycle(0,0,1,8'h05,0);
    check_all("ovf.byte5", 0, 4, 1, 9'h101, 1);
    cycle(0,1,0,8'h00,0);
    chk("ovf.pulse_end", 32'(overflow), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovf.read%0d", i), 32'({rx_first, rx_data}), 32'({(i == 1), 8'(i)}));
      cycle(0,0,0,8'h00,1);
    end
    chk("ovf.drained", 32'(rx_count), 32'd0);

    // Full FIFO: pop in the same cycle as a data byte does not make room.
    cycle(1,0,0,8'h00,0);
    cycle(0,0,1,8'h42,0);
    for (int i = 0; i < 4; i++) cycle(0,0,1,8'h11 + 8'(i),0);
    cycle(0,0,1,8'h99,1);
    check_all("pushpop", 0, 3, 1, 9'h012, 1);
    for (int i = 0; i < 3; i++) cycle(0,0,0,8'h00,1);
    cycle(0,1,0,8'h00,0);
    check_all("pushpop.drain", 0, 0, 0, 9'h014, 0);

    // Repeated start: both transactions' first bytes are flagged.
    cycle(1,0,0,8'h00,0);
    cycle(0,0,1,8'h42,0);
    cycle(0,0,1,8'h10,0);
    cycle(1,0,0,8'h00,0);
    cycle(0,0,1,8'h42,0);
    cycle(0,0,1,8'h20,0);
    check_all("rstart", 1, 2, 1, 9'h110, 0);
    cycle(0,0,0,8'h00,1);
    check_all("rstart.pop", 1, 1, 1, 9'h120, 0);

    // Asynchronous reset mid-transaction, then data without a new start is refused.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all("async_reset", 0, 0, 0, 9'h000, 0);
    @(negedge clk);
    reset = 1'b0;
    cycle(0,0,1,8'h30,0);
    check_all("post_reset.data", 0, 0, 0, 9'h000, 0);
    cycle(0,0,1,8'h42,0);
    check_all("post_reset.addr", 0, 0, 0, 9'h000, 0);

    // Random traffic against a transaction-level queue model.
    do_reset();
    model_q.delete();
    last_head = 9'h000;
    mode = 0; m_ack = 1'b0; m_first = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic st, sp, w, rd, do_push;
      logic [7:0] d;
      int sz, r;
      st = ($urandom_range(0, 15) == 0);
      sp = ($urandom_range(0, 19) == 0);
      w  = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 3) == 0);
      r  = $urandom_range(0, 3);
      d  = (r == 0) ? 8'h42 : (r == 1) ? 8'h43 : (r == 2) ? 8'h44 : 8'($urandom);
      sz = model_q.size();
      m_ovf = 1'b0;
      do_push = 1'b0;
      if (st) mode = 1;
      else if (sp) mode = 0;
      else if (w) begin
        if (mode == 1) begin
          if (d == 8'h42) begin m_ack = 1'b1; m_first = 1'b1; mode = 2; end
          else begin m_ack = 1'b0; mode = 3; end
        end else if (mode == 2) begin
          if (sz < 4) begin do_push = 1'b1; m_ack = 1'b1; end
          else begin m_ack = 1'b0; m_ovf = 1'b1; mode = 3; end
        end else m_ack = 1'b0;
      end
      if (rd && sz > 0) last_head = model_q.pop_front();
      if (do_push) begin
        model_q.push_back({m_first, d});
        m_first = 1'b0;
      end
      cycle(st, sp, w, d, rd);
      check_all($sformatf("rand%0d", n), m_ack, 3'(model_q.size()), model_q.size() != 0,
                (model_q.size() != 0) ? model_q[0] : last_head, m_ovf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
